multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
Main sequencing FSM for the multi-cycle variant of the core. One shared ALU serves PC increment, branch target, address generation and execution. The block walks each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK states and drives the ALUOp code consumed by the ALU control decoder. It also drives the datapath mux selects and the register-file and memory strobes, and stalls on a memory ready handshake.

Parameters:
MEM_WAIT_MAX, 15, max cycles a memory state waits for mem_ready before flagging bus_error; 0 disables the timeout.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
opcode  in  7  instruction register bits [6:0]
zero  in  1  ALU zero flag (combinational, current cycle)
mem_ready  in  1  memory completes current read/write this cycle
alu_op  out  2  00 add, 01 subtract/compare, 10 funct-decoded
fun7_mask  out  1  1 = ALU control must treat fun7 as 0 (I-type ALU)
alu_src_a  out  2  00 PC, 01 rs1, 10 old PC
alu_src_b  out  2  00 rs2, 01 constant 4, 10 immediate
pc_write  out  1  PC load enable
pc_src  out  1  0 ALU result, 1 ALUOut register
ir_write  out  1  instruction register load
iord  out  1  0 address = PC, 1 address = ALUOut
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
reg_write  out  1  register file write
mem_to_reg  out  1  write-back source: 0 ALUOut, 1 memory data register
instr_retired  out  1  registered 1-cycle pulse per completed instruction
bus_error  out  1  sticky: memory timeout occurred

Behaviour:
- State register is 4 bits. States: FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, EXEC_I, ALU_WB, BRANCH, TRAP.
- Outputs are decoded from the registered state, except pc_write and ir_write, which also depend on mem_ready and zero. Any output not listed for a state is 0.
- Reset (rst=1, async): state=FETCH, instr_retired=0, bus_error=0, wait counter=0.
  - While rst=1, all strobes (pc_write, ir_write, mem_read, mem_write, reg_write) are forced to 0.
- FETCH:
  - Outputs: mem_read=1, iord=0, alu_src_a=00, alu_src_b=01, alu_op=00, pc_src=0.
  - ir_write=pc_write=mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE on mem_ready=1.
- DECODE:
  - Outputs: alu_src_a=10, alu_src_b=10, alu_op=00 (branch target into ALUOut).
  - Next state by opcode: 0000011 -> MEM_ADDR, 0100011 -> MEM_ADDR, 0110011 -> EXEC_R, 0010011 -> EXEC_I, 1100011 -> BRANCH.
  - Any other opcode is illegal (see Optional Feature).
- MEM_ADDR: alu_src_a=01, alu_src_b=10, alu_op=00. Load goes to MEM_READ; store goes to MEM_WRITE. The opcode is held stable by the IR.
- MEM_READ: mem_read=1, iord=1. Wait for mem_ready, then go to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1; then FETCH.
- MEM_WRITE: mem_write=1, iord=1. Wait for mem_ready, then go to FETCH.
- EXEC_R: alu_src_a=01, alu_src_b=00, alu_op=10; then ALU_WB.
- EXEC_I: alu_src_a=01, alu_src_b=10, alu_op=10, fun7_mask=1; then ALU_WB.
- ALU_WB: reg_write=1, mem_to_reg=0; then FETCH.
- BRANCH: alu_src_a=01, alu_src_b=00, alu_op=01, pc_src=1, pc_write=zero; then FETCH.
- instr_retired is set for one cycle in the cycle after leaving MEM_WB, MEM_WRITE (with mem_ready), ALU_WB or BRANCH.
- Wait counter:
  - Counts consecutive mem_ready=0 cycles in FETCH, MEM_READ and MEM_WRITE.
  - Clears on state change.
  - If MEM_WAIT_MAX≠0 and the count reaches MEM_WAIT_MAX: bus_error is set, the state goes to FETCH, and no strobe fires.
  - The counter saturates and never wraps.
- mem_ready=1 in the same cycle the counter hits the limit: the ready wins and there is no error.
- rst asserted mid-instruction: abort immediately. No partial write-back is issued after reset.

Optional Feature:
ILLEGAL_TRAP_EN
- Defined: an illegal opcode in DECODE goes to TRAP. TRAP holds with all strobes 0 until rst, and instr_retired never pulses.
- Undefined: an illegal opcode is treated as a NOP. DECODE goes to FETCH and instr_retired pulses once.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - state enum/localparams
  - opcode constants (OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH)
  - ALUOp codes
  - alu_src_a / alu_src_b select codes
- One natural combinational sub-module, ctrl_opcode_decode, maps opcode to a one-hot instruction class plus an illegal flag.

Test Plan:
- R-type: opcode=0110011, mem_ready=1 in FETCH -> states FETCH, DECODE, EXEC_R (alu_op=10, src_b=00), ALU_WB (reg_write=1) -> instr_retired pulse in cycle 5.
- Load with 3 wait cycles: opcode=0000011, mem_ready low 3 cycles in MEM_READ -> mem_read=1, iord=1 held 4 cycles -> MEM_WB with mem_to_reg=1 -> 8 cycles total.
- Branch: opcode=1100011 -> BRANCH has alu_op=01, pc_src=1. zero=1 gives pc_write=1; zero=0 gives pc_write=0.
- Immediate: opcode=0010011 -> EXEC_I has fun7_mask=1, alu_src_b=10.
- Timeout: MEM_WAIT_MAX=4, mem_ready held 0 in FETCH -> bus_error=1 after 4 cycles; ir_write never asserted.
- Illegal opcode 1111111: TRAP is held with ILLEGAL_TRAP_EN; without it, the FSM returns to FETCH. Async rst pulse in MEM_WRITE -> mem_write=0 immediately and state=FETCH.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared constants and types for the multi-cycle control FSM: state codes,
// opcodes, ALUOp codes, ALU operand selects and the instruction class record.
package riscv_ctrl_pkg;

    localparam logic [3:0] ST_FETCH     = 4'd0;
    localparam logic [3:0] ST_DECODE    = 4'd1;
    localparam logic [3:0] ST_MEM_ADDR  = 4'd2;
    localparam logic [3:0] ST_MEM_READ  = 4'd3;
    localparam logic [3:0] ST_MEM_WB    = 4'd4;
    localparam logic [3:0] ST_MEM_WRITE = 4'd5;
    localparam logic [3:0] ST_EXEC_R    = 4'd6;
    localparam logic [3:0] ST_EXEC_I    = 4'd7;
    localparam logic [3:0] ST_ALU_WB    = 4'd8;
    localparam logic [3:0] ST_BRANCH    = 4'd9;
    localparam logic [3:0] ST_TRAP      = 4'd10;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_RS1   = 2'b01;
    localparam logic [1:0] SRC_A_OLDPC = 2'b10;

    localparam logic [1:0] SRC_B_RS2   = 2'b00;
    localparam logic [1:0] SRC_B_FOUR  = 2'b01;
    localparam logic [1:0] SRC_B_IMM   = 2'b10;

    typedef struct packed {
        logic load;
        logic store;
        logic rtype;
        logic itype;
        logic branch;
    } instr_class_t;

    // Counter must hold the limit; four bits minimum keeps the disabled case sane.
    function automatic int wait_cnt_width(input int max_wait);
        if (max_wait < 15) begin
            return 4;
        end else begin
            return $clog2(max_wait + 1);
        end
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the sequencing FSM (master) and the datapath (slave).
interface multicycle_control_if;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic [1:0] alu_op;
    logic       fun7_mask;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic       pc_write;
    logic       pc_src;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       instr_retired;
    logic       bus_error;

    modport master (
        input  opcode, zero, mem_ready,
        output alu_op, fun7_mask, alu_src_a, alu_src_b, pc_write, pc_src,
               ir_write, iord, mem_read, mem_write, reg_write, mem_to_reg,
               instr_retired, bus_error
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  alu_op, fun7_mask, alu_src_a, alu_src_b, pc_write, pc_src,
               ir_write, iord, mem_read, mem_write, reg_write, mem_to_reg,
               instr_retired, bus_error
    );
endinterface

// File: rtl/multicycle_control_opcode_decode.sv
// Classifies the IR opcode into a one-hot instruction class plus an illegal flag.
module ctrl_opcode_decode
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0]   opcode,
    output instr_class_t cls,
    output logic         illegal
);

    // One-hot class lookup
    always_comb begin
        cls     = 5'b00000;
        illegal = 1'b0;
        case (opcode)
            OP_LOAD:   cls.load   = 1'b1;
            OP_STORE:  cls.store  = 1'b1;
            OP_RTYPE:  cls.rtype  = 1'b1;
            OP_ITYPE:  cls.itype  = 1'b1;
            OP_BRANCH: cls.branch = 1'b1;
            default:   illegal    = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle core sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK with memory
// wait timeout. Define ILLEGAL_TRAP_EN to trap on illegal opcodes instead of NOP.
module multicycle_control
    import riscv_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15
)
(
    input  logic                  clk,
    input  logic                  rst,
    multicycle_control_if.master  bus
);

    localparam int            CW         = wait_cnt_width(MEM_WAIT_MAX);
    localparam logic [CW-1:0] WAIT_LIMIT = CW'(MEM_WAIT_MAX);
    localparam bit            TIMEOUT_EN = (MEM_WAIT_MAX != 0);

    logic [3:0]    state_q, state_d, next_state_s;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc_s;
    logic          bus_error_q, bus_error_d;
    logic          instr_retired_q, instr_retired_d;
    logic          wait_state_s, timeout_s;
    logic [1:0]    alu_op_s, alu_src_a_s, alu_src_b_s;
    logic          fun7_mask_s, pc_write_s, pc_src_s, ir_write_s, iord_s;
    logic          mem_read_s, mem_write_s, reg_write_s, mem_to_reg_s;
    instr_class_t  cls_s;
    logic          illegal_s;

    ctrl_opcode_decode u_decode (
        .opcode  (bus.opcode),
        .cls     (cls_s),
        .illegal (illegal_s)
    );

    // Per-state outputs and successor state
    always_comb begin
        next_state_s    = state_q;
        instr_retired_d = 1'b0;
        alu_op_s        = ALUOP_ADD;
        alu_src_a_s     = SRC_A_PC;
        alu_src_b_s     = SRC_B_RS2;
        fun7_mask_s     = 1'b0;
        pc_write_s      = 1'b0;
        pc_src_s        = 1'b0;
        ir_write_s      = 1'b0;
        iord_s          = 1'b0;
        mem_read_s      = 1'b0;
        mem_write_s     = 1'b0;
        reg_write_s     = 1'b0;
        mem_to_reg_s    = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_read_s   = 1'b1;
                alu_src_b_s  = SRC_B_FOUR;
                ir_write_s   = bus.mem_ready;
                pc_write_s   = bus.mem_ready;
                next_state_s = bus.mem_ready ? ST_DECODE : ST_FETCH;
            end
            ST_DECODE: begin
                alu_src_a_s = SRC_A_OLDPC;
                alu_src_b_s = SRC_B_IMM;
                if (illegal_s) begin
`ifdef ILLEGAL_TRAP_EN
                    next_state_s = ST_TRAP;
`else
                    next_state_s    = ST_FETCH;
                    instr_retired_d = 1'b1;
`endif
                end else if (cls_s.load || cls_s.store) begin
                    next_state_s = ST_MEM_ADDR;
                end else if (cls_s.rtype) begin
                    next_state_s = ST_EXEC_R;
                end else if (cls_s.itype) begin
                    next_state_s = ST_EXEC_I;
                end else if (cls_s.branch) begin
                    next_state_s = ST_BRANCH;
                end else begin
                    next_state_s = ST_FETCH;
                end
            end
            ST_MEM_ADDR: begin
                alu_src_a_s = SRC_A_RS1;
                alu_src_b_s = SRC_B_IMM;
                if (cls_s.load) begin
                    next_state_s = ST_MEM_READ;
                end else if (cls_s.store) begin
                    next_state_s = ST_MEM_WRITE;
                end else begin
                    next_state_s = ST_FETCH;
                end
            end
            ST_MEM_READ: begin
                mem_read_s   = 1'b1;
                iord_s       = 1'b1;
                next_state_s = bus.mem_ready ? ST_MEM_WB : ST_MEM_READ;
            end
            ST_MEM_WB: begin
                reg_write_s     = 1'b1;
                mem_to_reg_s    = 1'b1;
                next_state_s    = ST_FETCH;
                instr_retired_d = 1'b1;
            end
            ST_MEM_WRITE: begin
                mem_write_s     = 1'b1;
                iord_s          = 1'b1;
                next_state_s    = bus.mem_ready ? ST_FETCH : ST_MEM_WRITE;
                instr_retired_d = bus.mem_ready;
            end
            ST_EXEC_R: begin
                alu_src_a_s  = SRC_A_RS1;
                alu_src_b_s  = SRC_B_RS2;
                alu_op_s     = ALUOP_FUNCT;
                next_state_s = ST_ALU_WB;
            end
            ST_EXEC_I: begin
                alu_src_a_s  = SRC_A_RS1;
                alu_src_b_s  = SRC_B_IMM;
                alu_op_s     = ALUOP_FUNCT;
                fun7_mask_s  = 1'b1;
                next_state_s = ST_ALU_WB;
            end
            ST_ALU_WB: begin
                reg_write_s     = 1'b1;
                next_state_s    = ST_FETCH;
                instr_retired_d = 1'b1;
            end
            ST_BRANCH: begin
                alu_src_a_s     = SRC_A_RS1;
                alu_src_b_s     = SRC_B_RS2;
                alu_op_s        = ALUOP_SUB;
                pc_src_s        = 1'b1;
                pc_write_s      = bus.zero;
                next_state_s    = ST_FETCH;
                instr_retired_d = 1'b1;
            end
            ST_TRAP: begin
                next_state_s = ST_TRAP;
            end
            default: begin
                next_state_s = ST_FETCH;
            end
        endcase
    end

    // Memory wait supervision; a ready in the limit cycle takes priority
    always_comb begin
        wait_state_s = (state_q == ST_FETCH) || (state_q == ST_MEM_READ) ||
                       (state_q == ST_MEM_WRITE);
        cnt_inc_s    = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + {{(CW-1){1'b0}}, 1'b1};
        timeout_s    = TIMEOUT_EN && wait_state_s && !bus.mem_ready && (cnt_inc_s >= WAIT_LIMIT);
        state_d      = timeout_s ? ST_FETCH : next_state_s;
        bus_error_d  = bus_error_q | timeout_s;
        if (timeout_s || (state_d != state_q)) begin
            cnt_d = {CW{1'b0}};
        end else if (wait_state_s) begin
            cnt_d = cnt_inc_s;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State, wait counter and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_FETCH;
            cnt_q           <= {CW{1'b0}};
            bus_error_q     <= 1'b0;
            instr_retired_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            bus_error_q     <= bus_error_d;
            instr_retired_q <= instr_retired_d;
        end
    end

    // Strobes are held low for the whole reset pulse
    assign bus.pc_write      = rst ? 1'b0 : pc_write_s;
    assign bus.ir_write      = rst ? 1'b0 : ir_write_s;
    assign bus.mem_read      = rst ? 1'b0 : mem_read_s;
    assign bus.mem_write     = rst ? 1'b0 : mem_write_s;
    assign bus.reg_write     = rst ? 1'b0 : reg_write_s;
    assign bus.alu_op        = alu_op_s;
    assign bus.fun7_mask     = fun7_mask_s;
    assign bus.alu_src_a     = alu_src_a_s;
    assign bus.alu_src_b     = alu_src_b_s;
    assign bus.pc_src        = pc_src_s;
    assign bus.iord          = iord_s;
    assign bus.mem_to_reg    = mem_to_reg_s;
    assign bus.instr_retired = instr_retired_q;
    assign bus.bus_error     = bus_error_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: instruction-level reference that expands each
// instruction into its phase sequence and checks outputs every cycle.
module tb_multicycle_control;

    localparam int WAIT_MAX = 4;
    localparam int P_FETCH = 0, P_DEC = 1, P_ADDR = 2, P_RD = 3, P_MWB = 4, P_WR = 5;
    localparam int P_EXR = 6, P_EXI = 7, P_AWB = 8, P_BR = 9, P_TRAP = 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multicycle_control_if bus();
    multicycle_control #(.MEM_WAIT_MAX(WAIT_MAX)) dut (.clk(clk), .rst(rst), .bus(bus));

    int   checks = 0;
    int   failures = 0;
    int   cyc_count = 0;
    logic exp_ret, exp_berr;

    typedef struct {
        logic [6:0] op;
        int         fw;
        int         mw;
        logic       z;
        int         ncyc;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expected control word for a phase: {alu_op,f7,srcA,srcB,pcw,pcsrc,irw,iord,mrd,mwr,rw,m2r}
    function automatic logic [14:0] exp_vec(input int ph, input logic mr, input logic z);
        logic [1:0] aop, sa, sb;
        logic f7, pw, ps, irw, io, mrd, mwr, rw, m2r;
        {aop, sa, sb} = 6'b000000;
        {f7, pw, ps, irw, io, mrd, mwr, rw, m2r} = 9'b000000000;
        case (ph)
            P_FETCH: begin mrd = 1'b1; sb = 2'b01; irw = mr; pw = mr; end
            P_DEC:   begin sa = 2'b10; sb = 2'b10; end
            P_ADDR:  begin sa = 2'b01; sb = 2'b10; end
            P_RD:    begin mrd = 1'b1; io = 1'b1; end
            P_MWB:   begin rw = 1'b1; m2r = 1'b1; end
            P_WR:    begin mwr = 1'b1; io = 1'b1; end
            P_EXR:   begin sa = 2'b01; sb = 2'b00; aop = 2'b10; end
            P_EXI:   begin sa = 2'b01; sb = 2'b10; aop = 2'b10; f7 = 1'b1; end
            P_AWB:   begin rw = 1'b1; end
            P_BR:    begin sa = 2'b01; sb = 2'b00; aop = 2'b01; ps = 1'b1; pw = z; end
            default: ;
        endcase
        return {aop, f7, sa, sb, pw, ps, irw, io, mrd, mwr, rw, m2r};
    endfunction

    // One clock cycle of a phase; entered and left at posedge+1
    task automatic cyc(input int ph, input logic mr, input logic z, input logic ret);
        logic [14:0] act;
        bus.mem_ready = mr;
        bus.zero      = z;
        #4;
        act = {bus.alu_op, bus.fun7_mask, bus.alu_src_a, bus.alu_src_b, bus.pc_write, bus.pc_src,
               bus.ir_write, bus.iord, bus.mem_read, bus.mem_write, bus.reg_write, bus.mem_to_reg};
        check($sformatf("ctrl_word_phase%0d", ph), 32'(act), 32'(exp_vec(ph, mr, z)));
        check("instr_retired", 32'(bus.instr_retired), 32'(exp_ret));
        check("bus_error", 32'(bus.bus_error), 32'(exp_berr));
        exp_ret = ret;
        cyc_count++;
        @(posedge clk);
        #1;
    endtask

    // Memory wait phase; returns 1 when the wait ran out
    task automatic wait_phase(input int ph, input int nwait, output logic to);
        logic rdy;
        rdy = 1'b0;
        to  = 1'b0;
        for (int i = 0; i < WAIT_MAX && !rdy; i++) begin
            rdy = (i >= nwait);
            cyc(ph, rdy, rbit(), (ph == P_WR) && rdy);
            if (!rdy && (i + 1 == WAIT_MAX)) to = 1'b1;
        end
        if (to) exp_berr = 1'b1;
    endtask

    task automatic do_instr(input logic [6:0] op, input int fw, input int mw, input logic z,
                            output int ncyc);
        int   start;
        logic to;
        start      = cyc_count;
        bus.opcode = op;
        wait_phase(P_FETCH, fw, to);
        if (!to) begin
            case (op)
                7'b0000011: begin
                    cyc(P_DEC, rbit(), rbit(), 1'b0);
                    cyc(P_ADDR, rbit(), rbit(), 1'b0);
                    wait_phase(P_RD, mw, to);
                    if (!to) cyc(P_MWB, rbit(), rbit(), 1'b1);
                end
                7'b0100011: begin
                    cyc(P_DEC, rbit(), rbit(), 1'b0);
                    cyc(P_ADDR, rbit(), rbit(), 1'b0);
                    wait_phase(P_WR, mw, to);
                end
                7'b0110011: begin
                    cyc(P_DEC, rbit(), rbit(), 1'b0);
                    cyc(P_EXR, rbit(), rbit(), 1'b0);
                    cyc(P_AWB, rbit(), rbit(), 1'b1);
                end
                7'b0010011: begin
                    cyc(P_DEC, rbit(), rbit(), 1'b0);
                    cyc(P_EXI, rbit(), rbit(), 1'b0);
                    cyc(P_AWB, rbit(), rbit(), 1'b1);
                end
                7'b1100011: begin
                    cyc(P_DEC, rbit(), rbit(), 1'b0);
                    cyc(P_BR, rbit(), z, 1'b1);
                end
                default: begin
`ifdef ILLEGAL_TRAP_EN
                    cyc(P_DEC, rbit(), rbit(), 1'b0);
                    for (int k = 0; k < 3; k++) cyc(P_TRAP, rbit(), rbit(), 1'b0);
`else
                    cyc(P_DEC, rbit(), rbit(), 1'b1);
`endif
                end
            endcase
        end
        ncyc = cyc_count - start;
    endtask

    // Reset pulse from posedge+1; strobes must drop while rst is high
    task automatic apply_reset(input string tag);
        rst = 1'b1;
        #1;
        check({tag, "_strobes"}, 32'({bus.pc_write, bus.ir_write, bus.mem_read, bus.mem_write,
                                      bus.reg_write}), 32'd0);
        check({tag, "_retired"}, 32'(bus.instr_retired), 32'd0);
        check({tag, "_bus_error"}, 32'(bus.bus_error), 32'd0);
        check({tag, "_src_b"}, 32'(bus.alu_src_b), 32'd1);
        exp_ret  = 1'b0;
        exp_berr = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    vec_t tbl[8];
    int   n;
    int   fw, mw;
    logic [6:0] op;
    logic [6:0] legal_ops [5];

    initial begin
        tbl[0] = '{7'b0110011, 0, 0, 1'b0, 4};
        tbl[1] = '{7'b0000011, 0, 3, 1'b0, 8};
        tbl[2] = '{7'b1100011, 0, 0, 1'b1, 3};
        tbl[3] = '{7'b1100011, 1, 0, 1'b0, 4};
        tbl[4] = '{7'b0010011, 2, 0, 1'b0, 6};
        tbl[5] = '{7'b0100011, 1, 2, 1'b0, 7};
        tbl[6] = '{7'b0100011, 0, 3, 1'b0, 7};
        tbl[7] = '{7'b0000011, 0, 4, 1'b0, 7};
        legal_ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011};

        rst = 1'b1;
        bus.opcode = 7'b0000000;
        bus.mem_ready = 1'b0;
        bus.zero = 1'b0;
        exp_ret = 1'b0;
        exp_berr = 1'b0;
        @(posedge clk);
        #1;
        apply_reset("reset");

        for (int i = 0; i < 8; i++) begin
            do_instr(tbl[i].op, tbl[i].fw, tbl[i].mw, tbl[i].z, n);
            check($sformatf("vec%0d_cycles", i), 32'(n), 32'(tbl[i].ncyc));
        end
        check("load_timeout_sticky", 32'(bus.bus_error), 32'd1);

        // Fetch timeout from a clean state: four idle cycles, no IR load
        apply_reset("reset2");
        do_instr(7'b0110011, 4, 0, 1'b0, n);
        check("fetch_timeout_cycles", 32'(n), 32'd4);
        check("fetch_timeout_flag", 32'(bus.bus_error), 32'd1);
        apply_reset("reset3");

        // Reset while a store is waiting in MEM_WRITE
        bus.opcode = 7'b0100011;
        cyc(P_FETCH, 1'b1, 1'b0, 1'b0);
        cyc(P_DEC, 1'b0, 1'b0, 1'b0);
        cyc(P_ADDR, 1'b0, 1'b0, 1'b0);
        bus.mem_ready = 1'b0;
        #1;
        check("mem_write_before_rst", 32'(bus.mem_write), 32'd1);
        apply_reset("rst_in_store");
        do_instr(7'b0110011, 0, 0, 1'b0, n);
        check("after_rst_cycles", 32'(n), 32'd4);

        // Illegal opcode
        do_instr(7'b1111111, 0, 0, 1'b0, n);
`ifdef ILLEGAL_TRAP_EN
        check("illegal_trap_cycles", 32'(n), 32'd5);
        apply_reset("reset_trap");
`else
        check("illegal_nop_cycles", 32'(n), 32'd2);
`endif

        for (int i = 0; i < 300; i++) begin
            op = legal_ops[$urandom_range(0, 4)];
            fw = $urandom_range(0, WAIT_MAX);
            mw = $urandom_range(0, WAIT_MAX);
            do_instr(op, fw, mw, rbit(), n);
            if (bus.bus_error && ($urandom_range(0, 3) == 0)) apply_reset("rand_reset");
        end
        cyc(P_FETCH, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
